// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings, arbiter state encoding and idle bus constants.
package sdram_pkg;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_PREC = 4'b0010;
    localparam logic [3:0] CMD_WRI  = 4'b0100;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_BUST = 4'b0110;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

    localparam logic IDLE_BA_BIT   = 1'b1;
    localparam logic IDLE_ADDR_BIT = 1'b1;
endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the SDRAM bus to init/refresh/write/read in turn and muxes the
// granted requester's command, address and write data onto the device pins.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int DQ_W   = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);
    arb_state_e        state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [3:0]        cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    // On wr/rd contention the side that did not go last wins.
    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        cmd        = CMD_NOP;
        sdram_ba   = {BA_W{IDLE_BA_BIT}};
        sdram_addr = {ADDR_W{IDLE_ADDR_BIT}};
        case (state_q)
            ST_INIT: begin
                state_d    = init_end ? ST_ARBIT : ST_INIT;
                cmd        = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_ARBIT: begin
                state_d = aref_req          ? ST_AREF :
                          wr_req && rd_req  ? (last_wr_q ? ST_READ : ST_WRITE) :
                          wr_req            ? ST_WRITE :
                          rd_req            ? ST_READ : ST_ARBIT;
            end
            ST_AREF: begin
                state_d    = aref_end ? ST_ARBIT : ST_AREF;
                cmd        = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                state_d    = wr_end ? ST_ARBIT : ST_WRITE;
                last_wr_d  = wr_end ? 1'b1 : last_wr_q;
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                state_d    = rd_end ? ST_ARBIT : ST_READ;
                last_wr_d  = rd_end ? 1'b0 : last_wr_q;
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign aref_en      = (state_q == ST_AREF);
    assign wr_en        = (state_q == ST_WRITE);
    assign rd_en        = (state_q == ST_READ);
    assign sdram_cke    = 1'b1;
    assign sdram_dq_oe  = wr_sdram_en && wr_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed walk through init hold, priority, alternation,
// no-preemption, write data path and mid-transaction reset.
module tb_sdram_arbit;
    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sdram_arbit dut (
        .clk(clk), .rst(rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
        .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
        .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pins();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    endfunction

    function automatic logic [2:0] grants();
        return {aref_en, wr_en, rd_en};
    endfunction

    initial begin
        rst = 1'b1; init_end = 1'b0;
        init_cmd = 4'b0111; init_ba = 2'b00; init_addr = 13'h0400;
        aref_req = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001; aref_ba = 2'b01; aref_addr = 13'h0011;
        wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0123;
        wr_sdram_en = 1'b0; wr_sdram_data = 16'h0;
        rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 13'h0456;
        step();
        chk("rst_pins", 32'(pins()), 32'h7);
        chk("rst_addr", 32'(sdram_addr), 32'h0400);
        chk("rst_grants", 32'(grants()), 32'h0);
        chk("rst_cke", 32'(sdram_cke), 32'h1);
        chk("rst_oe_dq", 32'({sdram_dq_oe, sdram_dq_out}), 32'h0);

        rst = 1'b0; init_cmd = 4'b0010; wr_req = 1'b1;
        repeat (20) step();
        chk("init_hold_pins", 32'(pins()), 32'h2);
        chk("init_hold_wr_en", 32'(wr_en), 32'h0);

        init_end = 1'b1;
        step();
        chk("arbit_pins", 32'(pins()), 32'h7);
        chk("arbit_ba_addr", 32'({sdram_ba, sdram_addr}), 32'h7FFF);
        chk("arbit_grants", 32'(grants()), 32'h0);
        step();
        chk("write_grant", 32'(grants()), 32'h2);
        wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
        #1;
        chk("write_pins", 32'(pins()), 32'h4);
        chk("write_ba_addr", 32'({sdram_ba, sdram_addr}), 32'h4123);
        chk("write_dq", 32'({sdram_dq_oe, sdram_dq_out}), 32'h1A5A5);

        aref_req = 1'b1;
        step();
        chk("nopreempt_grant", 32'(grants()), 32'h2);
        chk("nopreempt_pins", 32'(pins()), 32'h4);
        rd_end = 1'b1;
        step();
        chk("stray_rd_end", 32'(grants()), 32'h2);
        rd_end = 1'b0; wr_end = 1'b1;
        #1;
        chk("end_cycle_grant", 32'(grants()), 32'h2);
        step();
        wr_end = 1'b0; wr_sdram_en = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
        #1;
        chk("gap_pins", 32'(pins()), 32'h7);
        chk("gap_grants", 32'(grants()), 32'h0);
        step();
        chk("aref_priority", 32'(grants()), 32'h4);
        chk("aref_pins", 32'(pins()), 32'h1);
        aref_end = 1'b1;
        step();
        aref_end = 1'b0; aref_req = 1'b0;
        chk("post_aref_arbit", 32'(grants()), 32'h0);
        step();
        chk("alt_read_after_write", 32'(grants()), 32'h1);
        wr_sdram_en = 1'b1;
        #1;
        chk("read_pins", 32'(pins()), 32'h5);
        chk("read_dq_blocked", 32'({sdram_dq_oe, sdram_dq_out}), 32'h0);
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk("read_drop", 32'(grants()), 32'h0);
        step();
        chk("alt_write", 32'(grants()), 32'h2);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        step();
        chk("alt_read", 32'(grants()), 32'h1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midread_rst_grant", 32'(grants()), 32'h0);
        chk("midread_rst_pins", 32'(pins()), 32'h2);
        chk("midread_rst_cke", 32'(sdram_cke), 32'h1);
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk("post_rst_arbit", 32'(grants()), 32'h0);
        step();
        chk("last_wr_cleared", 32'(grants()), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
